// File: rtl/sym_gen_pkg.sv
// Shared constants for the symbol generator: seven-segment table, LFSR mask,
// symbol index width and the seg() lookup helper.
package sym_gen_pkg;

  localparam int          SYM_IDX_W = 4;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Active-low seven-segment codes with dp in bit 7; element 0 is symbol 0.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hD8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] seg(input logic [SYM_IDX_W-1:0] idx);
    return SEG_TABLE[idx];
  endfunction

endpackage

// File: rtl/sym_lfsr.sv
// 16-bit right-shifting Galois LFSR with synchronous seed load.
// A zero seed would lock the register at zero, so it is replaced by SEED.
module sym_lfsr
  import sym_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk100M,
  input  logic        Rst,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic [15:0] state_reg;
  logic [15:0] shift_next;
  logic [15:0] state_next;

  // Each bit takes its upper neighbour, xored with the feedback bit where the mask is set.
  for (genvar gi = 0; gi < 16; gi++) begin : g_shift
    if (gi == 15) begin : g_top
      assign shift_next[gi] = LFSR_MASK[gi] & state_reg[0];
    end else begin : g_mid
      assign shift_next[gi] = state_reg[gi+1] ^ (LFSR_MASK[gi] & state_reg[0]);
    end
  end

  // Seed load wins over the free-running shift.
  always_comb begin
    state_next = shift_next;
    if (load) begin
      state_next = (seed == 16'h0000) ? SEED : seed;
    end
  end

  // State register; free-runs every cycle.
  always_ff @(posedge Clk100M) begin
    if (Rst) begin
      state_reg <= SEED;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/sym_gen_multi.sv
// Pseudo-random symbol generator for the symbol-counting game.
// Emits one symbol every symGenMax cycles while genSym is high, flags the
// target symbol and keeps saturating per-game counts.
// Optional feature: define SYMGEN_NO_REPEAT_EN to bump a symbol that equals
// the previous one within a game to the next index.
module sym_gen_multi
  import sym_gen_pkg::*;
#(
  parameter int          NUM_SYMS = 10,
  parameter int          PERIOD_W = 32,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                 Clk100M,
  input  logic                 Rst,
  input  logic                 genSym,
  input  logic [PERIOD_W-1:0]  symGenMax,
  input  logic [SYM_IDX_W-1:0] targetSym,
  input  logic                 seedLoad,
  input  logic [15:0]          seedVal,
  output logic                 generated,
  output logic                 special,
  output logic [SYM_IDX_W-1:0] symIdx,
  output logic [7:0]           generatedSym,
  output logic [7:0]           genCount,
  output logic [7:0]           specialCount
);

  localparam logic [4:0]           NUM_SYMS_EXT = 5'(NUM_SYMS);
  localparam logic [SYM_IDX_W-1:0] NUM_SYMS_LO  = SYM_IDX_W'(NUM_SYMS % 16);

  logic [15:0]          lfsr_state;
  logic                 lfsr_unused;
  logic [PERIOD_W-1:0]  cnt_reg;
  logic [PERIOD_W-1:0]  cnt_next;
  logic [PERIOD_W-1:0]  max_eff;
  logic                 tick;
  logic                 gen_sym_d_reg;
  logic                 game_start;
  logic [SYM_IDX_W-1:0] raw_idx;
  logic [SYM_IDX_W-1:0] idx_sel;
  logic [SYM_IDX_W-1:0] idx_emit;
  logic                 special_hit;

  logic                 generated_reg;
  logic                 special_reg;
  logic [SYM_IDX_W-1:0] sym_idx_reg;
  logic [7:0]           gen_sym_reg;
  logic [7:0]           gen_count_reg;
  logic [7:0]           special_count_reg;

  sym_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .Clk100M(Clk100M),
    .Rst    (Rst),
    .load   (seedLoad),
    .seed   (seedVal),
    .state  (lfsr_state)
  );

  // Only the low nibble picks the symbol.
  assign lfsr_unused = ^lfsr_state[15:SYM_IDX_W];

  assign game_start = genSym & ~gen_sym_d_reg;

  // Period decision; >= keeps a mid-period shrink of symGenMax from wrapping.
  always_comb begin
    max_eff  = (symGenMax == '0) ? PERIOD_W'(1) : symGenMax;
    tick     = genSym && (cnt_reg >= (max_eff - PERIOD_W'(1)));
    cnt_next = cnt_reg + PERIOD_W'(1);
    if (!genSym || tick) begin
      cnt_next = '0;
    end
  end

  // Period counter and delayed genSym for game-start detection.
  always_ff @(posedge Clk100M) begin
    if (Rst) begin
      cnt_reg       <= '0;
      gen_sym_d_reg <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      gen_sym_d_reg <= genSym;
    end
  end

  // Fold raw values beyond the alphabet back into range with one subtraction.
  always_comb begin
    raw_idx = lfsr_state[SYM_IDX_W-1:0];
    idx_sel = raw_idx;
    if ({1'b0, raw_idx} >= NUM_SYMS_EXT) begin
      idx_sel = raw_idx - NUM_SYMS_LO;
    end
  end

`ifdef SYMGEN_NO_REPEAT_EN
  localparam logic [SYM_IDX_W-1:0] LAST_IDX = SYM_IDX_W'(NUM_SYMS - 1);

  logic [SYM_IDX_W-1:0] prev_idx_reg;
  logic                 prev_valid_reg;

  // Replace a repeat of the previous symbol; the first symbol of a game is never altered.
  always_comb begin
    idx_emit = idx_sel;
    if (prev_valid_reg && !game_start && (idx_sel == prev_idx_reg)) begin
      idx_emit = (idx_sel == LAST_IDX) ? '0 : idx_sel + SYM_IDX_W'(1);
    end
  end

  // Remember the last emitted symbol within the current game.
  always_ff @(posedge Clk100M) begin
    if (Rst) begin
      prev_idx_reg   <= '0;
      prev_valid_reg <= 1'b0;
    end else if (tick) begin
      prev_idx_reg   <= idx_emit;
      prev_valid_reg <= 1'b1;
    end else if (game_start) begin
      prev_valid_reg <= 1'b0;
    end
  end
`else
  assign idx_emit = idx_sel;
`endif

  // An out-of-alphabet target can never match because idx_emit stays below NUM_SYMS.
  assign special_hit = (idx_emit == targetSym);

  // Symbol output registers: pulses for one cycle, symbol fields hold between ticks.
  always_ff @(posedge Clk100M) begin
    if (Rst) begin
      generated_reg <= 1'b0;
      special_reg   <= 1'b0;
      sym_idx_reg   <= '0;
      gen_sym_reg   <= 8'hFF;
    end else begin
      generated_reg <= tick;
      special_reg   <= tick && special_hit;
      if (tick) begin
        sym_idx_reg <= idx_emit;
        gen_sym_reg <= seg(idx_emit);
      end
    end
  end

  // Per-game saturating counters; a game start clears them and drops a coincident tick.
  always_ff @(posedge Clk100M) begin
    if (Rst || game_start) begin
      gen_count_reg     <= 8'd0;
      special_count_reg <= 8'd0;
    end else if (tick) begin
      if (gen_count_reg != 8'hFF) begin
        gen_count_reg <= gen_count_reg + 8'd1;
      end
      if (special_hit && (special_count_reg != 8'hFF)) begin
        special_count_reg <= special_count_reg + 8'd1;
      end
    end
  end

  assign generated    = generated_reg;
  assign special      = special_reg;
  assign symIdx       = sym_idx_reg;
  assign generatedSym = gen_sym_reg;
  assign genCount     = gen_count_reg;
  assign specialCount = special_count_reg;

endmodule
